mem_responder: RTL and testbench



---
 rtl/mem_responder_if.sv | 24 ++
 rtl/mem_responder.sv | 99 +++++++++
 tb/tb_mem_responder.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Four-phase REQ/ACK memory bus between the CPU control sequencer (master)
// and the main-memory responder (slave).
interface mem_responder_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) ();
  logic              REQ;
  logic              WE;
  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] DATA_IN;
  logic [DATA_W-1:0] DATA_OUT;
  logic              ACK;
  logic              BUSY;

  modport master (
    output REQ, WE, ADDR, DATA_IN,
    input  DATA_OUT, ACK, BUSY
  );

  modport slave (
    input  REQ, WE, ADDR, DATA_IN,
    output DATA_OUT, ACK, BUSY
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed main memory with a REQ/ACK handshake and configurable wait
// states; request fields are latched once in IDLE and ignored afterwards.
//
// state  | meaning
// IDLE   | waiting for REQ; latches WE/ADDR/DATA_IN when it arrives
// WAIT   | burning WAIT_CYCLES wait states on the down-counter
// ACCESS | single edge that commits the write or captures read data
// DONE   | ACK held until the initiator drops REQ
module mem_responder #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input logic            clk,
  input logic            REST,
  mem_responder_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_data_out;
  logic              r_ack;
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic              w_busy;

  assign w_busy       = (r_state != ST_IDLE);
  assign bus.BUSY     = w_busy;
  assign bus.ACK      = r_ack;
  assign bus.DATA_OUT = r_data_out;

  // Reset gates the commit so an aborted write can never land in the array.
  always_ff @(posedge clk) begin
    if (REST && (r_state == ST_ACCESS) && r_we) begin
      r_mem[r_addr] <= r_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!REST) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_data_out <= '0;
      r_ack      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.REQ) begin
            r_we   <= bus.WE;
            r_addr <= bus.ADDR;
            r_data <= bus.DATA_IN;
            if (WAIT_CYCLES == 0) begin
              r_state <= ST_ACCESS;
            end else begin
              r_cnt   <= CNT_INIT;
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd1) begin
            r_state <= ST_ACCESS;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_ACCESS: begin
          if (!r_we) begin
            r_data_out <= r_mem[r_addr];
          end
          r_ack   <= 1'b1;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (!bus.REQ) begin
            r_ack   <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with two wait states and one
// with none, read data checked against a scoreboard fed from a memory model.
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 clk = ~clk;

  mem_responder_if #(.ADDR_W(12), .DATA_W(16)) ifa ();
  mem_responder_if #(.ADDR_W(12), .DATA_W(16)) ifb ();

  mem_responder #(.ADDR_W(12), .DATA_W(16), .WAIT_CYCLES(2)) dut_a (
    .clk (clk),
    .REST(rst_a),
    .bus (ifa)
  );

  mem_responder #(.ADDR_W(12), .DATA_W(16), .WAIT_CYCLES(0)) dut_b (
    .clk (clk),
    .REST(rst_b),
    .bus (ifb)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] model_a [int];
  logic [15:0] model_b [int];
  logic [15:0] sb [$];
  logic [15:0] last_d [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit s, input logic req, input logic we,
                       input logic [11:0] a, input logic [15:0] d);
    if (s) begin
      ifb.REQ = req; ifb.WE = we; ifb.ADDR = a; ifb.DATA_IN = d;
    end else begin
      ifa.REQ = req; ifa.WE = we; ifa.ADDR = a; ifa.DATA_IN = d;
    end
  endtask

  task automatic set_req(input bit s, input logic r);
    if (s) ifb.REQ = r;
    else   ifa.REQ = r;
  endtask

  function automatic logic get_ack(input bit s);
    return s ? ifb.ACK : ifa.ACK;
  endfunction

  function automatic logic get_busy(input bit s);
    return s ? ifb.BUSY : ifa.BUSY;
  endfunction

  function automatic logic [15:0] get_dout(input bit s);
    return s ? ifb.DATA_OUT : ifa.DATA_OUT;
  endfunction

  // One full transaction. corrupt: change ADDR/WE/DATA_IN right after E0.
  // pulse: drop REQ right after E0. hold: extra cycles with REQ high in DONE.
  task automatic txn(input bit s, input logic we, input logic [11:0] a,
                     input logic [15:0] d, input int hold,
                     input bit corrupt, input bit pulse);
    int wc;
    int n;
    logic [15:0] exp;
    wc = s ? 0 : 2;
    if (we) begin
      if (s) model_b[int'(a)] = d;
      else   model_a[int'(a)] = d;
    end else begin
      sb.push_back(s ? model_b[int'(a)] : model_a[int'(a)]);
    end
    drive(s, 1'b1, we, a, d);
    tick();
    chk("busy_after_e0", 32'(get_busy(s)), 32'd1);
    if (corrupt) drive(s, 1'b1, 1'b1, a ^ 12'h030, 16'hDEAD);
    if (pulse) set_req(s, 1'b0);
    n = 0;
    while (!get_ack(s) && n < 20) begin
      tick();
      n++;
    end
    chk("ack_latency", 32'(n), 32'(wc + 1));
    if (!we) begin
      exp = sb.pop_front();
      chk("read_data", 32'(get_dout(s)), 32'(exp));
      last_d[s] = exp;
    end else begin
      chk("write_dout_hold", 32'(get_dout(s)), 32'(last_d[s]));
    end
    if (!pulse) begin
      for (int i = 0; i < hold; i++) begin
        tick();
        chk("ack_held", 32'(get_ack(s)), 32'd1);
        chk("busy_held", 32'(get_busy(s)), 32'd1);
      end
      set_req(s, 1'b0);
    end
    tick();
    chk("ack_fall", 32'(get_ack(s)), 32'd0);
    chk("busy_fall", 32'(get_busy(s)), 32'd0);
    chk("dout_after", 32'(get_dout(s)), 32'(last_d[s]));
    drive(s, 1'b0, 1'b0, 12'h000, 16'h0000);
    tick();
  endtask

  initial begin
    last_d[0] = 16'h0000;
    last_d[1] = 16'h0000;

    // Reset held two cycles with REQ asserted.
    rst_a = 1'b0;
    rst_b = 1'b0;
    drive(0, 1'b1, 1'b1, 12'h123, 16'hFFFF);
    drive(1, 1'b1, 1'b1, 12'h123, 16'hFFFF);
    tick();
    tick();
    chk("rst_dout_a", 32'(ifa.DATA_OUT), 32'h0);
    chk("rst_ack_a", 32'(ifa.ACK), 32'h0);
    chk("rst_busy_a", 32'(ifa.BUSY), 32'h0);
    chk("rst_dout_b", 32'(ifb.DATA_OUT), 32'h0);
    chk("rst_busy_b", 32'(ifb.BUSY), 32'h0);
    drive(0, 1'b0, 1'b0, 12'h000, 16'h0000);
    drive(1, 1'b0, 1'b0, 12'h000, 16'h0000);
    rst_a = 1'b1;
    rst_b = 1'b1;
    tick();
    chk("post_rst_busy_a", 32'(ifa.BUSY), 32'h0);

    // Write then read back.
    txn(0, 1'b1, 12'h123, 16'hBEEF, 0, 0, 0);
    txn(0, 1'b0, 12'h123, 16'h0000, 0, 0, 0);

    // Address extremes, no aliasing.
    txn(0, 1'b1, 12'h000, 16'h0001, 0, 0, 0);
    txn(0, 1'b1, 12'hFFF, 16'h8000, 0, 0, 0);
    txn(0, 1'b0, 12'h000, 16'h0000, 0, 0, 0);
    txn(0, 1'b0, 12'hFFF, 16'h0000, 0, 0, 0);

    // Inputs changed mid-read are ignored; REQ held 5 extra cycles.
    txn(0, 1'b1, 12'h010, 16'h1111, 0, 0, 0);
    txn(0, 1'b1, 12'h020, 16'h2222, 0, 0, 0);
    txn(0, 1'b0, 12'h010, 16'h0000, 5, 1, 0);
    txn(0, 1'b0, 12'h020, 16'h0000, 0, 0, 0);

    // Early REQ drop: ACK for exactly one cycle.
    txn(0, 1'b0, 12'h123, 16'h0000, 0, 0, 1);

    // Reset during WAIT of a write.
    txn(0, 1'b1, 12'h040, 16'h0F0F, 0, 0, 0);
    drive(0, 1'b1, 1'b1, 12'h040, 16'h5A5A);
    tick();
    tick();
    chk("wait_busy_a", 32'(ifa.BUSY), 32'h1);
    rst_a = 1'b0;
    drive(0, 1'b0, 1'b0, 12'h000, 16'h0000);
    tick();
    chk("midrst_ack_a", 32'(ifa.ACK), 32'h0);
    chk("midrst_busy_a", 32'(ifa.BUSY), 32'h0);
    chk("midrst_dout_a", 32'(ifa.DATA_OUT), 32'h0);
    last_d[0] = 16'h0000;
    rst_a = 1'b1;
    tick();
    txn(0, 1'b0, 12'h040, 16'h0000, 0, 0, 0);

    // Same abort with zero wait states: reset lands before the ACCESS edge.
    txn(1, 1'b1, 12'h040, 16'h0F0F, 0, 0, 0);
    drive(1, 1'b1, 1'b1, 12'h040, 16'h5A5A);
    tick();
    rst_b = 1'b0;
    drive(1, 1'b0, 1'b0, 12'h000, 16'h0000);
    tick();
    chk("midrst_ack_b", 32'(ifb.ACK), 32'h0);
    chk("midrst_busy_b", 32'(ifb.BUSY), 32'h0);
    last_d[1] = 16'h0000;
    rst_b = 1'b1;
    tick();
    txn(1, 1'b0, 12'h040, 16'h0000, 0, 0, 0);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
